// File: rtl/mul_pkg.sv
// Shared types and sizing helpers for the iterative multiplier.
package mul_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  // Number of busy iterations needed to retire all multiplier bits.
  function automatic int unsigned iter_count(input int unsigned dw, input int unsigned bpc);
    return dw / bpc;
  endfunction

  // Counter must hold the value iter_count itself.
  function automatic int unsigned cnt_width(input int unsigned dw, input int unsigned bpc);
    return $clog2(iter_count(dw, bpc) + 1);
  endfunction

endpackage

// File: rtl/mul_step.sv
// One radix-2^BITS_PER_CYCLE step of a shift-right accumulate multiplier.
// The partial product is added at the top half and the whole sum shifted
// right, so after all steps the accumulator holds the full product.
module mul_step #(
  parameter int unsigned DATAWIDTH      = 64,
  parameter int unsigned BITS_PER_CYCLE = 1
) (
  input  logic [2*DATAWIDTH-1:0]    acc,
  input  logic [DATAWIDTH-1:0]      mcand,
  input  logic [BITS_PER_CYCLE-1:0] digit,
  output logic [2*DATAWIDTH-1:0]    acc_next
);

  localparam int unsigned PpW  = DATAWIDTH + BITS_PER_CYCLE;
  localparam int unsigned SumW = 2 * DATAWIDTH + BITS_PER_CYCLE;

  logic [PpW-1:0]  pp;
  logic [SumW-1:0] sum;

  // Partial product, aligned add and shift.
  always_comb begin
    pp       = {{BITS_PER_CYCLE{1'b0}}, mcand} * {{DATAWIDTH{1'b0}}, digit};
    sum      = {{BITS_PER_CYCLE{1'b0}}, acc} + {pp, {DATAWIDTH{1'b0}}};
    acc_next = sum[SumW-1:BITS_PER_CYCLE];
  end

endmodule

// File: rtl/mul_iter.sv
// Iterative signed/unsigned multiplier with valid/ready handshakes.
// Operands are reduced to magnitudes at accept, iterated ITER times, and a
// final busy cycle applies the sign while loading the product register.
import mul_pkg::*;

module mul_iter #(
  parameter int unsigned DATAWIDTH      = 64,
  parameter int unsigned BITS_PER_CYCLE = 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [DATAWIDTH-1:0]   a,
  input  logic [DATAWIDTH-1:0]   b,
  input  logic                   is_signed,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [2*DATAWIDTH-1:0] prod
);

  localparam int unsigned ITER = iter_count(DATAWIDTH, BITS_PER_CYCLE);
  localparam int unsigned CNTW = cnt_width(DATAWIDTH, BITS_PER_CYCLE);

  state_t                 state_q, state_d;
  logic                   live_q;
  logic [DATAWIDTH-1:0]   mcand_q, mcand_d;
  logic [DATAWIDTH-1:0]   mplier_q, mplier_d;
  logic [2*DATAWIDTH-1:0] acc_q, acc_d, acc_step;
  logic [2*DATAWIDTH-1:0] prod_q, prod_d;
  logic [CNTW-1:0]        cnt_q, cnt_d;
  logic                   neg_q, neg_d;

  logic                   a_neg, b_neg;
  logic [DATAWIDTH-1:0]   a_mag, b_mag;

  // Magnitudes; -2^(W-1) negates to itself, which reads as 2^(W-1) unsigned.
  always_comb begin
    a_neg = is_signed & a[DATAWIDTH-1];
    b_neg = is_signed & b[DATAWIDTH-1];
    a_mag = a_neg ? -a : a;
    b_mag = b_neg ? -b : b;
  end

  mul_step #(
    .DATAWIDTH      (DATAWIDTH),
    .BITS_PER_CYCLE (BITS_PER_CYCLE)
  ) u_step (
    .acc      (acc_q),
    .mcand    (mcand_q),
    .digit    (mplier_q[BITS_PER_CYCLE-1:0]),
    .acc_next (acc_step)
  );

  // live_q keeps in_ready low until the first edge after reset release.
  assign in_ready  = (state_q == IDLE) && live_q;
  assign out_valid = (state_q == DONE);
  assign prod      = prod_q;

  // Next-state and datapath control.
  always_comb begin
    state_d  = state_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    prod_d   = prod_q;
    cnt_d    = cnt_q;
    neg_d    = neg_q;
    unique case (state_q)
      IDLE: begin
        if (in_valid && in_ready) begin
          mcand_d  = a_mag;
          mplier_d = b_mag;
          neg_d    = a_neg ^ b_neg;
          acc_d    = '0;
          cnt_d    = CNTW'(ITER);
          state_d  = BUSY;
        end
      end
      BUSY: begin
        if (cnt_q != '0) begin
          acc_d    = acc_step;
          mplier_d = mplier_q >> BITS_PER_CYCLE;
          cnt_d    = cnt_q - CNTW'(1);
        end else begin
          prod_d  = neg_q ? -acc_q : acc_q;
          state_d = DONE;
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers, all cleared by asynchronous reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      live_q   <= 1'b0;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      prod_q   <= '0;
      cnt_q    <= '0;
      neg_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      live_q   <= 1'b1;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      prod_q   <= prod_d;
      cnt_q    <= cnt_d;
      neg_q    <= neg_d;
    end
  end

endmodule

// File: tb/tb_mul_iter.sv
// Scoreboard bench for mul_iter across four width / radix configurations.
module tb_mul_iter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, out_ready, is_signed;
  logic [63:0] a, b;
  int          sel;
  int          cur_w, cur_lat;

  logic          ir0, ir1, ir2, ir3, ov0, ov1, ov2, ov3;
  logic [15:0]   p0, p1;
  logic [127:0]  p2, p3;
  logic          in_ready_m, out_valid_m;
  logic [127:0]  prod_m;

  logic [127:0] sb_q[$];
  int           checks = 0;
  int           errors = 0;

  always #5 clk = ~clk;

  mul_iter #(.DATAWIDTH(8), .BITS_PER_CYCLE(1)) u_d0 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid && (sel == 0)), .in_ready(ir0),
    .a(a[7:0]), .b(b[7:0]), .is_signed(is_signed), .out_valid(ov0),
    .out_ready(out_ready && (sel == 0)), .prod(p0));
  mul_iter #(.DATAWIDTH(8), .BITS_PER_CYCLE(4)) u_d1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid && (sel == 1)), .in_ready(ir1),
    .a(a[7:0]), .b(b[7:0]), .is_signed(is_signed), .out_valid(ov1),
    .out_ready(out_ready && (sel == 1)), .prod(p1));
  mul_iter #(.DATAWIDTH(64), .BITS_PER_CYCLE(2)) u_d2 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid && (sel == 2)), .in_ready(ir2),
    .a(a), .b(b), .is_signed(is_signed), .out_valid(ov2),
    .out_ready(out_ready && (sel == 2)), .prod(p2));
  mul_iter #(.DATAWIDTH(64), .BITS_PER_CYCLE(4)) u_d3 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid && (sel == 3)), .in_ready(ir3),
    .a(a), .b(b), .is_signed(is_signed), .out_valid(ov3),
    .out_ready(out_ready && (sel == 3)), .prod(p3));

  always_comb begin
    in_ready_m  = 1'b0;
    out_valid_m = 1'b0;
    prod_m      = '0;
    case (sel)
      0: begin in_ready_m = ir0; out_valid_m = ov0; prod_m = {112'b0, p0}; end
      1: begin in_ready_m = ir1; out_valid_m = ov1; prod_m = {112'b0, p1}; end
      2: begin in_ready_m = ir2; out_valid_m = ov2; prod_m = p2; end
      3: begin in_ready_m = ir3; out_valid_m = ov3; prod_m = p3; end
      default: ;
    endcase
  end

  task automatic check_val(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s (dut %0d): got %0h expected %0h", tag, sel, got, exp);
    end
  endtask

  // Reference: sign-extend to 128 bits, native multiply, trim to 2w bits.
  function automatic logic [127:0] ref_mul(input logic [63:0] x, input logic [63:0] y,
                                           input logic sg, input int w);
    logic [127:0] xe, ye, r;
    xe = {64'b0, x};
    ye = {64'b0, y};
    if (sg) begin
      xe = $signed(xe << (128 - w)) >>> (128 - w);
      ye = $signed(ye << (128 - w)) >>> (128 - w);
    end
    r = xe * ye;
    if (w < 64) r = r & ((128'b1 << (2 * w)) - 128'b1);
    return r;
  endfunction

  function automatic logic [63:0] rnd_op(input int w);
    logic [63:0] m, v;
    m = (w == 64) ? {64{1'b1}} : ((64'b1 << w) - 64'b1);
    case ($urandom_range(0, 7))
      0:       v = '0;
      1:       v = m;
      2:       v = 64'b1 << (w - 1);
      3:       v = 64'd1;
      default: v = {$urandom, $urandom} & m;
    endcase
    return v;
  endfunction

  task automatic use_dut(input int s);
    int bpc;
    sel   = s;
    cur_w = (s < 2) ? 8 : 64;
    case (s)
      0:       bpc = 1;
      2:       bpc = 2;
      default: bpc = 4;
    endcase
    cur_lat = cur_w / bpc + 1;
  endtask

  // Directed transaction; call and return at a falling edge.
  task automatic run_op(input logic [63:0] x, input logic [63:0] y, input logic sg,
                        input logic [127:0] exp, input int hold);
    int lat;
    lat = 0;
    while (!in_ready_m && lat < 100) begin
      @(negedge clk);
      lat++;
    end
    check_val("ready_wait", in_ready_m, 1'b1);
    a = x; b = y; is_signed = sg; in_valid = 1'b1;
    sb_q.push_back(exp);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    a = {$urandom, $urandom}; b = {$urandom, $urandom}; is_signed = ~sg;
    lat = 0;
    while (!out_valid_m && lat < 200) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
    check_val("latency", lat, cur_lat);
    for (int i = 0; i < hold; i++) begin
      check_val("hold_valid", out_valid_m, 1'b1);
      check_val("hold_ready", in_ready_m, 1'b0);
      check_val("hold_prod", prod_m, exp);
      @(posedge clk);
      @(negedge clk);
    end
    out_ready = 1'b1;
    check_val("result", prod_m, sb_q.pop_front());
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    check_val("idle_valid", out_valid_m, 1'b0);
    check_val("idle_ready", in_ready_m, 1'b1);
    check_val("retained", prod_m, exp);
  endtask

  // Random handshakes on both sides; operands churn every cycle.
  task automatic rand_phase(input int n);
    int pushed, popped, cyc;
    pushed = 0; popped = 0; cyc = 0;
    while ((pushed < n || sb_q.size() != 0) && cyc < 30000) begin
      in_valid  = (pushed < n) ? 1'($urandom_range(0, 1)) : 1'b0;
      out_ready = 1'($urandom_range(0, 1));
      a         = rnd_op(cur_w);
      b         = rnd_op(cur_w);
      is_signed = 1'($urandom_range(0, 1));
      if (out_valid_m && out_ready) begin
        check_val("sb_underflow", sb_q.size() == 0, 1'b0);
        if (sb_q.size() != 0) check_val("rand_prod", prod_m, sb_q.pop_front());
        popped++;
      end
      if (in_valid && in_ready_m) begin
        sb_q.push_back(ref_mul(a, b, is_signed, cur_w));
        pushed++;
      end
      @(posedge clk);
      @(negedge clk);
      cyc++;
    end
    in_valid  = 1'b0;
    out_ready = 1'b0;
    check_val("sb_drained", sb_q.size(), 0);
    check_val("rand_count", popped, n);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; is_signed = 1'b0;
    a = '0; b = '0;
    use_dut(0);
    #12;
    for (int s = 0; s < 4; s++) begin
      use_dut(s);
      #1;
      check_val("rst_prod", prod_m, '0);
      check_val("rst_valid", out_valid_m, 1'b0);
      check_val("rst_ready", in_ready_m, 1'b0);
    end
    use_dut(0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check_val("ready_after_rst", in_ready_m, 1'b1);

    run_op(64'hFF, 64'hFF, 1'b0, 128'hFE01, 0);
    run_op(64'h80, 64'h80, 1'b1, 128'h4000, 0);
    run_op(64'hFD, 64'h05, 1'b1, 128'hFFF1, 0);
    run_op(64'h80, 64'h01, 1'b1, 128'hFF80, 0);
    run_op(64'h7F, 64'h80, 1'b1, 128'hC080, 0);
    run_op(64'h5A, 64'h3C, 1'b0, 128'h1518, 20);

    // Abort an operation at its fourth busy cycle.
    a = 64'h37; b = 64'h2B; is_signed = 1'b0; in_valid = 1'b1;
    sb_q.push_back(128'h093D);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (4) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check_val("midrst_valid", out_valid_m, 1'b0);
    check_val("midrst_prod", prod_m, '0);
    check_val("midrst_ready", in_ready_m, 1'b0);
    sb_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check_val("ready_after_midrst", in_ready_m, 1'b1);
    run_op(64'h37, 64'h2B, 1'b0, 128'h093D, 0);

    use_dut(1);
    run_op(64'h0C, 64'h0B, 1'b0, 128'h0084, 0);
    run_op(64'h00, 64'hD7, 1'b0, 128'h0000, 0);
    run_op(64'hFF, 64'hFF, 1'b1, 128'h0001, 0);

    use_dut(2);
    run_op(64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b1,
           128'h4000_0000_0000_0000_0000_0000_0000_0000, 0);
    run_op(64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0,
           128'hFFFF_FFFF_FFFF_FFFE_0000_0000_0000_0001, 0);

    for (int s = 0; s < 4; s++) begin
      use_dut(s);
      rand_phase(150);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mul_iter.md
MUL_ITER -- requirements
Module: mul_iter

Interface
REQ-001 Parameter DATAWIDTH, default 64: operand width in bits, SHALL be at least 2.
REQ-002 Parameter BITS_PER_CYCLE, default 1: multiplier bits retired per busy cycle; SHALL be one of 1, 2 or 4 and SHALL divide DATAWIDTH.
REQ-003 Port clk, input, 1: rising-edge clock; the block SHALL use one clock.
REQ-004 Port rst_n, input, 1: reset; SHALL be asynchronous and active-low.
REQ-005 Port in_valid, input, 1: operands and mode are valid.
REQ-006 Port in_ready, output, 1: block can accept operands.
REQ-007 Port a, input, DATAWIDTH: multiplicand.
REQ-008 Port b, input, DATAWIDTH: multiplier.
REQ-009 Port is_signed, input, 1: 1 = two's-complement operands, 0 = unsigned.
REQ-010 Port out_valid, output, 1: prod holds a finished result.
REQ-011 Port out_ready, input, 1: consumer takes the result.
REQ-012 Port prod, output, 2*DATAWIDTH: full-width product.

Function
REQ-013 The block SHALL implement the FSM states IDLE, BUSY and DONE.
REQ-014 in_ready SHALL be 1 only in IDLE, and out_valid SHALL be 1 only in DONE.
REQ-015 An accept SHALL occur on a rising edge when in_valid=1 and in_ready=1; on accept the block SHALL latch a, b and is_signed, load the iteration counter with ITER=DATAWIDTH/BITS_PER_CYCLE, clear the accumulator and go to BUSY.
REQ-016 Operands SHALL be sampled only at accept; input changes at any other time SHALL have no effect.
REQ-017 In BUSY, each cycle SHALL add (multiplicand magnitude x the next BITS_PER_CYCLE multiplier bits, LSB first), suitably shifted, into the 2*DATAWIDTH accumulator and SHALL decrement the counter.
REQ-018 After exactly ITER BUSY cycles the block SHALL enter DONE, so out_valid rises exactly ITER+1 rising edges after the accept edge.
REQ-019 In signed mode, operands SHALL be converted to magnitudes before iteration, and the result SHALL be negated (two's complement, 2*DATAWIDTH bits) when the operand signs differ.
REQ-020 Magnitude of -2^(DATAWIDTH-1) SHALL be represented exactly as the unsigned value 2^(DATAWIDTH-1).
REQ-021 In unsigned mode, prod SHALL equal a*b exactly; in signed mode, prod SHALL equal the exact signed product. No truncation or overflow is permitted in either mode.
REQ-022 In DONE, prod SHALL be held stable while out_ready=0, for unlimited back-pressure.
REQ-023 In DONE with out_ready=1, the block SHALL return to IDLE on that edge; a new accept SHALL NOT occur in the same cycle.
REQ-024 prod SHALL retain the last result after the return to IDLE until the next DONE.
REQ-025 A zero operand SHALL still take the full ITER cycles; there is no early termination, so latency is data-independent.

Reset
REQ-026 On rst_n=0 the block SHALL immediately force state=IDLE, in_ready=0 while rst_n is low, out_valid=0, prod=0, accumulator=0 and counter=0.
REQ-027 in_ready SHALL rise in the first cycle after rst_n deasserts.
REQ-028 Reset during BUSY or DONE SHALL discard the operation with no output produced.
REQ-029 All flops SHALL use asynchronous-assert reset; deassertion SHALL be assumed synchronised externally.

Structure
REQ-030 A shared package mul_pkg SHALL hold the state enum (IDLE, BUSY, DONE) and a constant function computing ITER and the counter width ($clog2(ITER+1)).
REQ-031 One sub-module mul_step SHALL be used: a combinational partial-product adder taking accumulator, multiplicand magnitude and a BITS_PER_CYCLE-bit digit, and returning the next accumulator.
REQ-032 Sign handling, the FSM and the handshake SHALL live in mul_iter.

Verification (DATAWIDTH=8 unless noted)
REQ-033 Unsigned, BITS_PER_CYCLE=1: a=0xFF, b=0xFF -> out_valid exactly 9 edges after accept, prod=0xFE01.
REQ-034 Signed: a=0x80, b=0x80 -> prod=0x4000; a=0xFD, b=0x05 -> prod=0xFFF1; a=0x80, b=0x01 -> prod=0xFF80.
REQ-035 BITS_PER_CYCLE=4: a=0x0C, b=0x0B unsigned -> prod=0x0084 with latency 3 edges; a=0x00 -> prod=0, latency unchanged.
REQ-036 Back-pressure: out_ready held 0 for 20 cycles in DONE -> prod and out_valid stable, in_ready=0; then out_ready=1 for one cycle -> IDLE next edge, in_ready=1.
REQ-037 Reset mid-operation: rst_n pulsed low at BUSY cycle 4 -> out_valid=0 and prod=0 immediately; a new op after release completes correctly with no stale data.
REQ-038 Random: 10k operand pairs per mode with DATAWIDTH=64, BITS_PER_CYCLE in {1,2,4}, and random in_valid/out_ready -> every prod matches the reference model, with no lost or duplicated results.
